// File: rtl/es_pkg.sv
// rtl/es_pkg.sv - shared state encodings and sizing helpers for the I/O unit
package es_pkg;

    typedef enum logic [1:0] {
        IN_IDLE         = 2'd0,
        IN_WAIT_PRESS   = 2'd1,
        IN_WAIT_RELEASE = 2'd2
    } in_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE   = 2'd0,
        OUT_CONV   = 2'd1,
        OUT_COMMIT = 2'd2
    } out_state_e;

    // Decimal digits needed for a data_w-bit unsigned value: ceil(data_w*log10(2)).
    function automatic int bcd_w(input int data_w);
        return (data_w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/conversor_bcd_seq.sv
// rtl/conversor_bcd_seq.sv - sequential double-dabble binary to BCD converter
module conversor_bcd_seq #(
    parameter int DATA_W = 32,
    parameter int BCD_W  = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [DATA_W-1:0]    bin_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [4*BCD_W-1:0]   bcd_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0]  bin_q, bin_d;
    logic [4*BCD_W-1:0] bcd_q, bcd_d, adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;

    // done_o flags the final shift cycle; bcd_o holds the result from the next cycle on.
    always_comb begin
        for (int i = 0; i < BCD_W; i++) begin
            adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        end
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_o = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
        if (start_i && !busy_q) begin
            bin_d  = bin_i;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d = {adj[4*BCD_W-2:0], bin_q[DATA_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (done_o) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/unidade_es_parametrizada.sv
// rtl/unidade_es_parametrizada.sv - handshaked switch input and BCD display output for the CPU
module unidade_es_parametrizada
    import es_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int SW_W         = 9,
    parameter int DIGITS       = 3,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enter,
    input  logic [SW_W-1:0]       entradaSwitch,
    input  logic                  in_req,
    output logic                  in_valid,
    output logic [DATA_W-1:0]     in_data,
    input  logic                  out_req,
    input  logic [DATA_W-1:0]     out_data,
    output logic                  out_ready,
    output logic                  stall,
    output logic [4*DIGITS-1:0]   bcd_digits,
    output logic                  negativo,
    output logic                  overflow
);

    localparam int BCD_W = bcd_w(DATA_W);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC);

    logic              enter_meta_q, enter_sync_q;
    logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
    logic              db_level_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic              db_hit, db_fall, db_rise;

    in_state_e         in_state_q, in_state_d;
    logic [DATA_W-1:0] in_data_q, in_data_d;
    logic              in_valid_q, in_valid_d;

    out_state_e        out_state_q, out_state_d;
    logic              sign_q, sign_d, zero_q, zero_d;
    logic [4*DIGITS-1:0] bcd_digits_q, bcd_digits_d;
    logic              negativo_q, negativo_d, overflow_q, overflow_d;
    logic [DATA_W-1:0] magnitude;
    logic              conv_start, conv_busy, conv_done, high_digits_nz;
    logic [4*BCD_W-1:0] conv_bcd;

    // The button idles high; the debounced level commits on the DEBOUNCE_CYC-th differing sample.
    assign db_hit  = (enter_sync_q != db_level_q) && (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1));
    assign db_fall = db_hit & db_level_q;
    assign db_rise = db_hit & ~db_level_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enter_meta_q <= 1'b1;
            enter_sync_q <= 1'b1;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            db_level_q   <= 1'b1;
            db_cnt_q     <= '0;
        end else begin
            enter_meta_q <= enter;
            enter_sync_q <= enter_meta_q;
            sw_meta_q    <= entradaSwitch;
            sw_sync_q    <= sw_meta_q;
            if (enter_sync_q == db_level_q) begin
                db_cnt_q <= '0;
            end else if (db_hit) begin
                db_level_q <= enter_sync_q;
                db_cnt_q   <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    // in_req is still high during the in_valid cycle; that stale request must not re-arm.
    always_comb begin
        in_state_d = in_state_q;
        in_data_d  = in_data_q;
        in_valid_d = 1'b0;
        case (in_state_q)
            IN_IDLE: begin
                if (in_req && !in_valid_q) in_state_d = IN_WAIT_PRESS;
            end
            IN_WAIT_PRESS: begin
                if (!in_req) begin
                    in_state_d = IN_IDLE;
                end else if (db_fall) begin
                    in_data_d  = DATA_W'($signed(sw_sync_q));
                    in_state_d = IN_WAIT_RELEASE;
                end
            end
            IN_WAIT_RELEASE: begin
                if (!in_req) begin
                    in_state_d = IN_IDLE;
                end else if (db_rise) begin
                    in_valid_d = 1'b1;
                    in_state_d = IN_IDLE;
                end
            end
            default: in_state_d = IN_IDLE;
        endcase
    end

    // An unsigned DATA_W-bit magnitude already represents |most negative| exactly.
    assign magnitude = out_data[DATA_W-1] ? (~out_data + DATA_W'(1)) : out_data;

    always_comb begin
        high_digits_nz = 1'b0;
        for (int i = DIGITS; i < BCD_W; i++) begin
            high_digits_nz = high_digits_nz | (conv_bcd[4*i +: 4] != 4'd0);
        end
    end

    always_comb begin
        out_state_d  = out_state_q;
        sign_d       = sign_q;
        zero_d       = zero_q;
        bcd_digits_d = bcd_digits_q;
        negativo_d   = negativo_q;
        overflow_d   = overflow_q;
        conv_start   = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (out_req && !conv_busy) begin
                    conv_start  = 1'b1;
                    sign_d      = out_data[DATA_W-1];
                    zero_d      = (out_data == '0);
                    out_state_d = OUT_CONV;
                end
            end
            OUT_CONV: begin
                if (conv_done) out_state_d = OUT_COMMIT;
            end
            OUT_COMMIT: begin
                bcd_digits_d = conv_bcd[4*DIGITS-1:0];
                negativo_d   = sign_q & ~zero_q;
                overflow_d   = high_digits_nz;
                out_state_d  = OUT_IDLE;
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_state_q   <= IN_IDLE;
            in_data_q    <= '0;
            in_valid_q   <= 1'b0;
            out_state_q  <= OUT_IDLE;
            sign_q       <= 1'b0;
            zero_q       <= 1'b0;
            bcd_digits_q <= '0;
            negativo_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            in_state_q   <= in_state_d;
            in_data_q    <= in_data_d;
            in_valid_q   <= in_valid_d;
            out_state_q  <= out_state_d;
            sign_q       <= sign_d;
            zero_q       <= zero_d;
            bcd_digits_q <= bcd_digits_d;
            negativo_q   <= negativo_d;
            overflow_q   <= overflow_d;
        end
    end

    conversor_bcd_seq #(
        .DATA_W (DATA_W),
        .BCD_W  (BCD_W)
    ) u_conversor (
        .clk_i   (clock),
        .rst_ni  (reset),
        .start_i (conv_start),
        .bin_i   (magnitude),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    assign in_valid   = in_valid_q;
    assign in_data    = in_data_q;
    assign out_ready  = (out_state_q == OUT_IDLE);
    assign stall      = (in_req & ~in_valid_q) | (out_req & ~out_ready);
    assign bcd_digits = bcd_digits_q;
    assign negativo   = negativo_q;
    assign overflow   = overflow_q;

endmodule
